// File: rtl/riscv_mdsched_pkg.sv
// Shared types and constants for the mul/div sequencer.
// Optional trivial-op bypass is selected by RISCV_MDSCHED_FASTPATH_EN in riscv_muldiv_sched.
package riscv_mdsched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DIV_REM_BIT = 1;
  localparam int DIV_W_BIT   = 2;

  localparam logic SEL_MUL = 1'b0;
  localparam logic SEL_DIV = 1'b1;

endpackage

// File: rtl/riscv_mdsched_watchdog.sv
// Cycle counter that flags the enabled cycle on which the count would reach LIMIT.
// Cleared while the unit is being started, counts while the unit is busy.
module riscv_mdsched_watchdog
  import riscv_mdsched_pkg::*;
#(
  parameter int LIMIT = 80,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Fires in the cycle whose increment brings the count to LIMIT.
  assign expire = en && (count_reg == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/riscv_muldiv_sched.sv
// Execute-stage sequencer for the shared multi-cycle mul/div unit.
// Define RISCV_MDSCHED_FASTPATH_EN to complete trivial ops without starting the unit.
module riscv_muldiv_sched
  import riscv_mdsched_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 80,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic            i_riscv_mdsched_clk,
  input  logic            i_riscv_mdsched_rst,
  input  logic            i_riscv_mdsched_globstall,
  input  logic            i_riscv_mdsched_flush,
  input  logic            i_riscv_mdsched_mul_en,
  input  logic            i_riscv_mdsched_div_en,
  input  logic [2:0]      i_riscv_mdsched_mulctrl,
  input  logic [2:0]      i_riscv_mdsched_divctrl,
  input  logic [XLEN-1:0] i_riscv_mdsched_rs1data,
  input  logic [XLEN-1:0] i_riscv_mdsched_rs2data,
  input  logic            i_riscv_mdsched_unit_done,
  input  logic [XLEN-1:0] i_riscv_mdsched_unit_result,
  output logic            o_riscv_mdsched_unit_start,
  output logic            o_riscv_mdsched_unit_sel,
  output logic [XLEN-1:0] o_riscv_mdsched_unit_opa,
  output logic [XLEN-1:0] o_riscv_mdsched_unit_opb,
  output logic [2:0]      o_riscv_mdsched_unit_ctrl,
  output logic            o_riscv_mdsched_unit_kill,
  output logic            o_riscv_mdsched_stall,
  output logic            o_riscv_mdsched_valid,
  output logic [XLEN-1:0] o_riscv_mdsched_result,
  output logic            o_riscv_mdsched_timeout
);

  state_t          state_reg;
  logic            start_reg;
  logic            kill_reg;
  logic            timeout_reg;
  logic            valid_reg;
  logic            sel_reg;
  logic [2:0]      ctrl_reg;
  logic [XLEN-1:0] opa_reg;
  logic [XLEN-1:0] opb_reg;
  logic [XLEN-1:0] result_reg;

  logic            req;
  logic            sel_next;
  logic [2:0]      ctrl_next;
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;
  logic            wd_expire;

  assign req       = i_riscv_mdsched_mul_en | i_riscv_mdsched_div_en;
  assign sel_next  = i_riscv_mdsched_mul_en ? SEL_MUL : SEL_DIV;
  assign ctrl_next = i_riscv_mdsched_mul_en ? i_riscv_mdsched_mulctrl : i_riscv_mdsched_divctrl;

`ifdef RISCV_MDSCHED_FASTPATH_EN
  logic [XLEN-1:0] rem_by_zero;

  always_comb begin
    fast_hit    = 1'b0;
    fast_result = '0;
    rem_by_zero = i_riscv_mdsched_divctrl[DIV_W_BIT]
                ? {{(XLEN-32){i_riscv_mdsched_rs1data[31]}}, i_riscv_mdsched_rs1data[31:0]}
                : i_riscv_mdsched_rs1data;
    if (sel_next == SEL_MUL) begin
      fast_hit = (i_riscv_mdsched_rs1data == '0) || (i_riscv_mdsched_rs2data == '0);
    end else if (i_riscv_mdsched_rs2data == '0) begin
      fast_hit    = 1'b1;
      fast_result = i_riscv_mdsched_divctrl[DIV_REM_BIT] ? rem_by_zero : '1;
    end
  end
`else
  assign fast_hit    = 1'b0;
  assign fast_result = '0;
`endif

  riscv_mdsched_watchdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_watchdog (
    .clk    (i_riscv_mdsched_clk),
    .rst    (i_riscv_mdsched_rst),
    .clr    (state_reg == ISSUE),
    .en     (state_reg == BUSY),
    .expire (wd_expire)
  );

  // Flush is checked first in every busy state so it overrides done, timeout and globstall.
  always_ff @(posedge i_riscv_mdsched_clk) begin
    if (i_riscv_mdsched_rst) begin
      state_reg   <= IDLE;
      start_reg   <= 1'b0;
      kill_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      valid_reg   <= 1'b0;
      sel_reg     <= 1'b0;
      ctrl_reg    <= '0;
      opa_reg     <= '0;
      opb_reg     <= '0;
      result_reg  <= '0;
    end else begin
      start_reg   <= 1'b0;
      kill_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req && !i_riscv_mdsched_flush) begin
            opa_reg  <= i_riscv_mdsched_rs1data;
            opb_reg  <= i_riscv_mdsched_rs2data;
            sel_reg  <= sel_next;
            ctrl_reg <= ctrl_next;
            if (fast_hit) begin
              result_reg <= fast_result;
              valid_reg  <= 1'b1;
              state_reg  <= DONE;
            end else begin
              start_reg <= 1'b1;
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (i_riscv_mdsched_flush) begin
            kill_reg  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (i_riscv_mdsched_flush) begin
            kill_reg  <= 1'b1;
            state_reg <= IDLE;
          end else if (i_riscv_mdsched_unit_done) begin
            result_reg <= i_riscv_mdsched_unit_result;
            valid_reg  <= 1'b1;
            state_reg  <= DONE;
          end else if (wd_expire) begin
            result_reg  <= '0;
            valid_reg   <= 1'b1;
            timeout_reg <= 1'b1;
            kill_reg    <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (i_riscv_mdsched_flush || !i_riscv_mdsched_globstall) begin
            valid_reg <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_riscv_mdsched_stall = ((state_reg == IDLE) && req && !i_riscv_mdsched_flush)
                               || (state_reg == ISSUE) || (state_reg == BUSY);

  assign o_riscv_mdsched_unit_start = start_reg;
  assign o_riscv_mdsched_unit_sel   = sel_reg;
  assign o_riscv_mdsched_unit_opa   = opa_reg;
  assign o_riscv_mdsched_unit_opb   = opb_reg;
  assign o_riscv_mdsched_unit_ctrl  = ctrl_reg;
  assign o_riscv_mdsched_unit_kill  = kill_reg;
  assign o_riscv_mdsched_valid      = valid_reg;
  assign o_riscv_mdsched_result     = result_reg;
  assign o_riscv_mdsched_timeout    = timeout_reg;

endmodule

// File: tb/tb_riscv_muldiv_sched.sv
// Self-checking bench for riscv_muldiv_sched with an emulated mul/div unit.
// Covers the RISCV_MDSCHED_FASTPATH_EN bypass when the macro is defined for the build.
module tb_riscv_muldiv_sched;

  localparam int XLEN = 64;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            globstall, flush, mul_en, div_en, unit_done;
  logic [2:0]      mulctrl, divctrl;
  logic [XLEN-1:0] rs1, rs2, unit_result;
  logic            start, sel, kill, stall, valid, timeout;
  logic [XLEN-1:0] opa, opb, result;
  logic [2:0]      ctrl;

  int tests_run    = 0;
  int tests_failed = 0;

  int              o_stall, o_start_cnt, o_start_cyc, o_kill_cnt, o_kill_cyc;
  int              o_to_cnt, o_valid_cnt, o_first_valid;
  logic            o_sel, o_res_changed;
  logic [2:0]      o_ctrl;
  logic [XLEN-1:0] o_opa, o_opb, o_result;

  always #5 clk = ~clk;

  riscv_muldiv_sched #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .i_riscv_mdsched_clk         (clk),
    .i_riscv_mdsched_rst         (rst),
    .i_riscv_mdsched_globstall   (globstall),
    .i_riscv_mdsched_flush       (flush),
    .i_riscv_mdsched_mul_en      (mul_en),
    .i_riscv_mdsched_div_en      (div_en),
    .i_riscv_mdsched_mulctrl     (mulctrl),
    .i_riscv_mdsched_divctrl     (divctrl),
    .i_riscv_mdsched_rs1data     (rs1),
    .i_riscv_mdsched_rs2data     (rs2),
    .i_riscv_mdsched_unit_done   (unit_done),
    .i_riscv_mdsched_unit_result (unit_result),
    .o_riscv_mdsched_unit_start  (start),
    .o_riscv_mdsched_unit_sel    (sel),
    .o_riscv_mdsched_unit_opa    (opa),
    .o_riscv_mdsched_unit_opb    (opb),
    .o_riscv_mdsched_unit_ctrl   (ctrl),
    .o_riscv_mdsched_unit_kill   (kill),
    .o_riscv_mdsched_stall       (stall),
    .o_riscv_mdsched_valid       (valid),
    .o_riscv_mdsched_result      (result),
    .o_riscv_mdsched_timeout     (timeout)
  );

  task automatic idle_inputs();
    globstall = 0; flush = 0; mul_en = 0; div_en = 0; unit_done = 0;
    mulctrl = 0; divctrl = 0; rs1 = 0; rs2 = 0; unit_result = 0;
  endtask

  // Drives one instruction like the execute stage would (request held until it advances or is
  // flushed), answers start with done after `lat` cycles (lat<0: never) and records what it sees.
  task automatic run_op(input logic m, input logic d, input logic [2:0] mctl, input logic [2:0] dctl,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input int lat,
                        input int hold, input int flush_at, input logic [XLEN-1:0] res, input int ncyc);
    int   done_cyc = -1;
    int   gs_used  = 0;
    logic req_live = 1'b1;
    o_stall = 0; o_start_cnt = 0; o_start_cyc = -1; o_kill_cnt = 0; o_kill_cyc = -1;
    o_to_cnt = 0; o_valid_cnt = 0; o_first_valid = -1; o_res_changed = 0;
    o_sel = 1'bx; o_ctrl = 'x; o_opa = 'x; o_opb = 'x; o_result = 'x;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      mul_en = req_live & m; div_en = req_live & d;
      mulctrl = mctl; divctrl = dctl; rs1 = a; rs2 = b;
      flush = (c == flush_at);
      globstall = 0;
      if (valid && gs_used < hold) begin globstall = 1; gs_used++; end
      unit_done   = (c == done_cyc);
      unit_result = unit_done ? res : {$urandom, $urandom};
      @(negedge clk);
      if (stall) o_stall++;
      if (start) begin
        if (o_start_cnt == 0) begin
          o_start_cyc = c; o_sel = sel; o_ctrl = ctrl; o_opa = opa; o_opb = opb;
          if (lat >= 0) done_cyc = c + lat;
        end
        o_start_cnt++;
      end
      if (kill) begin o_kill_cnt++; o_kill_cyc = c; end
      if (timeout) o_to_cnt++;
      if (valid) begin
        if (o_valid_cnt == 0) o_first_valid = c;
        else if (result !== o_result) o_res_changed = 1;
        o_valid_cnt++;
        o_result = result;
      end
      if (req_live && (flush || (!stall && !globstall))) req_live = 0;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests_run++;
    if ({valid, start, kill, timeout, stall, sel} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b required 000000", {valid, start, kill, timeout, stall, sel});
    end
    tests_run++;
    if ({opa, opb, result, ctrl} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: opa=%h opb=%h result=%h ctrl=%0d required all 0", opa, opb, result, ctrl);
    end
  endtask

  task automatic test_basic_mul();
    run_op(1, 0, 3'd2, 3'd0, 64'd3, 64'd5, 4, 0, -1, 64'd15, 14);
    tests_run++;
    if (o_start_cnt !== 1 || o_start_cyc !== 1) begin
      tests_failed++; $display("FAIL mul_start: count=%0d cycle=%0d required 1 at 1", o_start_cnt, o_start_cyc);
    end
    tests_run++;
    if (o_stall !== 6) begin tests_failed++; $display("FAIL mul_stall: got %0d required 6", o_stall); end
    tests_run++;
    if (o_valid_cnt !== 1 || o_first_valid !== 6 || o_result !== 64'd15) begin
      tests_failed++;
      $display("FAIL mul_result: valid %0d cyc from %0d result %0d required 1 from 6 result 15", o_valid_cnt, o_first_valid, o_result);
    end
    tests_run++;
    if (o_sel !== 1'b0 || o_opa !== 64'd3 || o_opb !== 64'd5 || o_ctrl !== 3'd2) begin
      tests_failed++; $display("FAIL mul_latch: sel=%b opa=%0d opb=%0d ctrl=%0d required 0 3 5 2", o_sel, o_opa, o_opb, o_ctrl);
    end
    tests_run++;
    if (o_kill_cnt !== 0 || o_to_cnt !== 0) begin
      tests_failed++; $display("FAIL mul_nokill: kill=%0d timeout=%0d required 0 0", o_kill_cnt, o_to_cnt);
    end
  endtask

  task automatic test_div_globstall();
    logic [XLEN-1:0] a = {$urandom, $urandom};
    logic [XLEN-1:0] b = {32'd0, $urandom} | 64'd1;
    run_op(0, 1, 3'd0, 3'd1, a, b, 3, 3, -1, a / b, 16);
    tests_run++;
    if (o_start_cnt !== 1) begin tests_failed++; $display("FAIL div_gs_start: got %0d required 1", o_start_cnt); end
    tests_run++;
    if (o_valid_cnt !== 4 || o_first_valid !== 5) begin
      tests_failed++; $display("FAIL div_gs_valid: %0d cycles from %0d required 4 from 5", o_valid_cnt, o_first_valid);
    end
    tests_run++;
    if (o_result !== a / b || o_res_changed !== 1'b0 || o_sel !== 1'b1) begin
      tests_failed++; $display("FAIL div_gs_result: got %h changed=%b sel=%b required %h 0 1", o_result, o_res_changed, o_sel, a / b);
    end
  endtask

  task automatic test_flush();
    run_op(1, 0, 3'd0, 3'd0, 64'd11, 64'd13, 6, 0, 4, 64'd99, 14);
    tests_run++;
    if (o_kill_cnt !== 1 || o_kill_cyc !== 5 || o_stall !== 5) begin
      tests_failed++; $display("FAIL flush_busy: kill %0d at %0d stall %0d required 1 at 5 stall 5", o_kill_cnt, o_kill_cyc, o_stall);
    end
    tests_run++;
    if (o_valid_cnt !== 0 || o_to_cnt !== 0) begin
      tests_failed++; $display("FAIL flush_late_done: valid %0d timeout %0d required 0 0", o_valid_cnt, o_to_cnt);
    end
    run_op(0, 1, 3'd0, 3'd0, 64'd11, 64'd13, 3, 0, 1, 64'd99, 10);
    tests_run++;
    if (o_kill_cnt !== 1 || o_kill_cyc !== 2 || o_stall !== 2 || o_valid_cnt !== 0) begin
      tests_failed++; $display("FAIL flush_issue: kill %0d at %0d stall %0d valid %0d required 1 at 2 stall 2 valid 0", o_kill_cnt, o_kill_cyc, o_stall, o_valid_cnt);
    end
    run_op(1, 0, 3'd0, 3'd0, 64'd11, 64'd13, 3, 0, 0, 64'd99, 8);
    tests_run++;
    if (o_stall !== 0 || o_start_cnt !== 0 || o_valid_cnt !== 0) begin
      tests_failed++; $display("FAIL flush_idle: stall %0d start %0d valid %0d required 0 0 0", o_stall, o_start_cnt, o_valid_cnt);
    end
  endtask

  task automatic test_timeout();
    run_op(1, 0, 3'd1, 3'd0, 64'd6, 64'd7, -1, 0, -1, 64'd42, 16);
    tests_run++;
    if (o_to_cnt !== 1 || o_kill_cnt !== 1 || o_kill_cyc !== 2 + TO) begin
      tests_failed++; $display("FAIL timeout_pulse: timeout %0d kill %0d at %0d required 1 1 at %0d", o_to_cnt, o_kill_cnt, o_kill_cyc, 2 + TO);
    end
    tests_run++;
    if (o_valid_cnt !== 1 || o_first_valid !== 2 + TO || o_result !== '0 || o_stall !== 2 + TO) begin
      tests_failed++; $display("FAIL timeout_result: valid %0d from %0d result %h stall %0d required 1 from %0d 0 stall %0d", o_valid_cnt, o_first_valid, o_result, o_stall, 2 + TO, 2 + TO);
    end
    // Done in the last allowed busy cycle beats the watchdog.
    run_op(1, 0, 3'd1, 3'd0, 64'd6, 64'd7, TO, 0, -1, 64'd42, 16);
    tests_run++;
    if (o_to_cnt !== 0 || o_kill_cnt !== 0 || o_result !== 64'd42 || o_valid_cnt !== 1) begin
      tests_failed++; $display("FAIL timeout_edge_done: timeout %0d kill %0d result %0d valid %0d required 0 0 42 1", o_to_cnt, o_kill_cnt, o_result, o_valid_cnt);
    end
    run_op(1, 0, 3'd1, 3'd0, 64'd6, 64'd7, TO + 1, 0, -1, 64'd42, 16);
    tests_run++;
    if (o_to_cnt !== 1 || o_result !== '0 || o_valid_cnt !== 1) begin
      tests_failed++; $display("FAIL timeout_edge_late: timeout %0d result %0d valid %0d required 1 0 1", o_to_cnt, o_result, o_valid_cnt);
    end
  endtask

  task automatic test_both_en();
    run_op(1, 1, 3'd3, 3'd6, 64'd21, 64'd4, 2, 0, -1, 64'd84, 10);
    tests_run++;
    if (o_sel !== 1'b0 || o_ctrl !== 3'd3 || o_result !== 64'd84 || o_start_cnt !== 1) begin
      tests_failed++; $display("FAIL both_en: sel %b ctrl %0d result %0d start %0d required 0 3 84 1", o_sel, o_ctrl, o_result, o_start_cnt);
    end
  endtask

  task automatic test_fastpath();
`ifdef RISCV_MDSCHED_FASTPATH_EN
    run_op(0, 1, 3'd0, 3'd0, 64'd7, 64'd0, 2, 0, -1, 64'd5, 8);
    tests_run++;
    if (o_start_cnt !== 0 || o_stall !== 1 || o_first_valid !== 1 || o_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++; $display("FAIL fast_divq: start %0d stall %0d valid at %0d result %h required 0 1 1 all-ones", o_start_cnt, o_stall, o_first_valid, o_result);
    end
    run_op(0, 1, 3'd0, 3'd2, 64'd7, 64'd0, 2, 0, -1, 64'd5, 8);
    tests_run++;
    if (o_start_cnt !== 0 || o_stall !== 1 || o_result !== 64'd7) begin
      tests_failed++; $display("FAIL fast_divr: start %0d stall %0d result %h required 0 1 7", o_start_cnt, o_stall, o_result);
    end
    run_op(0, 1, 3'd0, 3'd6, 64'h0000_0001_8000_0000, 64'd0, 2, 0, -1, 64'd5, 8);
    tests_run++;
    if (o_start_cnt !== 0 || o_result !== 64'hFFFF_FFFF_8000_0000) begin
      tests_failed++; $display("FAIL fast_divrw: start %0d result %h required 0 ffffffff80000000", o_start_cnt, o_result);
    end
    run_op(1, 0, 3'd0, 3'd0, 64'd0, 64'd9, 2, 0, -1, 64'd5, 8);
    tests_run++;
    if (o_start_cnt !== 0 || o_stall !== 1 || o_result !== 64'd0) begin
      tests_failed++; $display("FAIL fast_mul0: start %0d stall %0d result %h required 0 1 0", o_start_cnt, o_stall, o_result);
    end
`else
    run_op(0, 1, 3'd0, 3'd0, 64'd7, 64'd0, 2, 0, -1, 64'hFFFF_FFFF_FFFF_FFFF, 10);
    tests_run++;
    if (o_start_cnt !== 1 || o_stall !== 4 || o_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++; $display("FAIL nofast_div0: start %0d stall %0d result %h required 1 4 all-ones", o_start_cnt, o_stall, o_result);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic            m    = 1'($urandom_range(0, 1));
      logic [2:0]      mctl = 3'($urandom);
      logic [2:0]      dctl = 3'($urandom);
      logic [XLEN-1:0] a    = {$urandom, $urandom} | 64'd1;
      logic [XLEN-1:0] b    = {$urandom_range(0, 1) ? $urandom : 32'd0, $urandom} | 64'd1;
      int              lat  = $urandom_range(1, 6);
      int              hold = $urandom_range(0, 3);
      logic [XLEN-1:0] exp_res = m ? a * b : (dctl[1] ? a % b : a / b);
      run_op(m, !m, mctl, dctl, a, b, lat, hold, -1, exp_res, lat + hold + 8);
      tests_run++;
      if (o_start_cnt !== 1 || o_stall !== 2 + lat || o_valid_cnt !== 1 + hold || o_first_valid !== 2 + lat) begin
        tests_failed++;
        $display("FAIL rand%0d_timing: start %0d stall %0d valid %0d from %0d required 1 %0d %0d from %0d",
                 i, o_start_cnt, o_stall, o_valid_cnt, o_first_valid, 2 + lat, 1 + hold, 2 + lat);
      end
      tests_run++;
      if (o_result !== exp_res || o_res_changed !== 1'b0 || o_sel !== !m || o_opa !== a || o_opb !== b
          || o_ctrl !== (m ? mctl : dctl)) begin
        tests_failed++;
        $display("FAIL rand%0d_data: result %h sel %b opa %h opb %h ctrl %0d required %h %b %h %h %0d",
                 i, o_result, o_sel, o_opa, o_opb, o_ctrl, exp_res, !m, a, b, m ? mctl : dctl);
      end
    end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    mul_en = 1; rs1 = 64'd2; rs2 = 64'd3;
    repeat (3) @(posedge clk);
    #1 rst = 1; mul_en = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    tests_run++;
    if ({stall, kill, valid, start, timeout} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_midop: stall/kill/valid/start/timeout=%b required 00000", {stall, kill, valid, start, timeout});
    end
  endtask

  initial begin
    test_reset();
    test_basic_mul();
    test_div_globstall();
    test_flush();
    test_timeout();
    test_both_en();
    test_fastpath();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
